// File: rtl/roi_pkg.sv
// Shared definitions for the ROI insertion blocks: FSM states and the
// bit positions of the x/y fields inside a packed corner word.
package roi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } roi_state_e;

  localparam int X_MSB = 26;
  localparam int X_LSB = 16;
  localparam int Y_MSB = 9;
  localparam int Y_LSB = 0;
  localparam int X_W   = X_MSB - X_LSB + 1;
  localparam int Y_W   = Y_MSB - Y_LSB + 1;

  function automatic logic [X_W-1:0] xy_x(input logic [31:0] xy);
    return xy[X_MSB:X_LSB];
  endfunction

  function automatic logic [Y_W-1:0] xy_y(input logic [31:0] xy);
    return xy[Y_MSB:Y_LSB];
  endfunction

endpackage

// File: rtl/roi_raster_cnt.sv
// Column/row raster counters with start-of-frame, end-of-line and
// end-of-frame flags; both counters wrap to zero after the last pixel.
module roi_raster_cnt #(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 600,
  parameter int CW     = 10,
  parameter int RW     = 10
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cx,
  output logic [RW-1:0] cy,
  output logic          sof,
  output logic          eol,
  output logic          eof
);

  logic [CW-1:0] cx_reg;
  logic [RW-1:0] cy_reg;

  assign cx  = cx_reg;
  assign cy  = cy_reg;
  assign sof = (cx_reg == '0) && (cy_reg == '0);
  assign eol = (cx_reg == CW'(WIDTH - 1));
  assign eof = eol && (cy_reg == RW'(HEIGHT - 1));

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cx_reg <= '0;
      cy_reg <= '0;
    end else if (clr) begin
      cx_reg <= '0;
      cy_reg <= '0;
    end else if (en) begin
      if (eol) begin
        cx_reg <= '0;
        cy_reg <= eof ? '0 : cy_reg + 1'b1;
      end else begin
        cx_reg <= cx_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/roi_insert_axis.sv
// Places a streamed ROI into a full WIDTH x HEIGHT raster, emitting FILL
// outside the rectangle, behind a single-register AXI-Stream output stage.
module roi_insert_axis
  import roi_pkg::*;
#(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 600,
  parameter int BIT_D  = 8,
  parameter int BIT_C  = 32,
  parameter int FILL   = 0
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [BIT_D-1:0] s_tdata_i,
  input  logic             s_tvalid_i,
  output logic             s_tready_o,
  input  logic             s_tlast_i,
  input  logic [BIT_C-1:0] xy_0_i,
  input  logic [BIT_C-1:0] xy_1_i,
  output logic [BIT_D-1:0] m_tdata_o,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic             m_tuser_o,
  output logic             m_tlast_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  roi_state_e       state_reg, state_next;
  logic [X_W-1:0]   xl_reg, xr_reg, x0, x1, xl_next, xr_next;
  logic [Y_W-1:0]   yt_reg, yb_reg, y0, y1, yt_next, yb_next;
  logic             early_reg, drain_reg, err_reg;
  logic             m_tvalid_reg, m_tuser_reg, m_tlast_reg;
  logic [BIT_D-1:0] m_tdata_reg, load_data;
  logic [CW-1:0]    cx;
  logic [RW-1:0]    cy;
  logic             sof, eol, eof;
  logic             s_tready, load, take, cnt_clr;
  logic             in_roi, at_corner, adv, corners_ok;

  assign x0 = xy_x(32'(xy_0_i));
  assign x1 = xy_x(32'(xy_1_i));
  assign y0 = xy_y(32'(xy_0_i));
  assign y1 = xy_y(32'(xy_1_i));

  assign xl_next    = (x0 < x1) ? x0 : x1;
  assign xr_next    = (x0 < x1) ? x1 : x0;
  assign yt_next    = (y0 < y1) ? y0 : y1;
  assign yb_next    = (y0 < y1) ? y1 : y0;
  assign corners_ok = (32'(xr_next) < 32'(WIDTH)) && (32'(yb_next) < 32'(HEIGHT));

  // After an early tlast the rest of the rectangle is treated as outside.
  assign in_roi = (32'(cx) >= 32'(xl_reg)) && (32'(cx) <= 32'(xr_reg)) &&
                  (32'(cy) >= 32'(yt_reg)) && (32'(cy) <= 32'(yb_reg)) && !early_reg;
  assign at_corner = (32'(cx) == 32'(xr_reg)) && (32'(cy) == 32'(yb_reg));
  assign adv       = !m_tvalid_reg || m_tready_i;
  assign cnt_clr   = (state_reg == IDLE);

  roi_raster_cnt #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .CW     (CW),
    .RW     (RW)
  ) u_cnt (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .clr    (cnt_clr),
    .en     (load),
    .cx     (cx),
    .cy     (cy),
    .sof    (sof),
    .eol    (eol),
    .eof    (eof)
  );

  always_comb begin
    state_next = state_reg;
    s_tready   = 1'b0;
    load       = 1'b0;
    take       = 1'b0;
    load_data  = BIT_D'(FILL);
    case (state_reg)
      IDLE: begin
        if (s_tvalid_i && corners_ok) state_next = RUN;
      end
      RUN: begin
        if (in_roi) begin
          // Inside the ROI the raster waits for real pixels, never FILL.
          s_tready = adv;
          if (adv && s_tvalid_i) begin
            load      = 1'b1;
            take      = 1'b1;
            load_data = s_tdata_i;
          end
        end else begin
          load = adv;
        end
        if (load && eof) begin
          state_next = (drain_reg || (take && at_corner && !s_tlast_i)) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        s_tready = 1'b1;
        if (s_tvalid_i && s_tlast_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_reg    <= IDLE;
      xl_reg       <= '0;
      xr_reg       <= '0;
      yt_reg       <= '0;
      yb_reg       <= '0;
      early_reg    <= 1'b0;
      drain_reg    <= 1'b0;
      err_reg      <= 1'b0;
      m_tvalid_reg <= 1'b0;
      m_tuser_reg  <= 1'b0;
      m_tlast_reg  <= 1'b0;
      m_tdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && s_tvalid_i) begin
        xl_reg    <= xl_next;
        xr_reg    <= xr_next;
        yt_reg    <= yt_next;
        yb_reg    <= yb_next;
        early_reg <= 1'b0;
        drain_reg <= 1'b0;
        if (!corners_ok) err_reg <= 1'b1;
      end
      if (take) begin
        if (s_tlast_i && !at_corner) begin
          err_reg   <= 1'b1;
          early_reg <= 1'b1;
        end
        if (at_corner && !s_tlast_i) begin
          err_reg   <= 1'b1;
          drain_reg <= 1'b1;
        end
      end
      if (load) begin
        m_tvalid_reg <= 1'b1;
        m_tdata_reg  <= load_data;
        m_tuser_reg  <= sof;
        m_tlast_reg  <= eol;
      end else if (m_tready_i) begin
        m_tvalid_reg <= 1'b0;
      end
    end
  end

  assign s_tready_o = s_tready;
  assign m_tdata_o  = m_tdata_reg;
  assign m_tvalid_o = m_tvalid_reg;
  assign m_tuser_o  = m_tuser_reg;
  assign m_tlast_o  = m_tlast_reg;
  assign busy_o     = (state_reg != IDLE);
  assign err_o      = err_reg;

endmodule

// File: tb/tb_roi_insert_axis.sv
// Scoreboard bench for roi_insert_axis on an 8x4 frame: directed ROI
// frames, backpressure, early/late tlast, bad corners and mid-frame reset.
module tb_roi_insert_axis;

  localparam int W = 8;
  localparam int H = 4;

  logic        clk_i = 1'b0;
  logic        arst_i = 1'b1;
  logic [7:0]  s_tdata_i = '0;
  logic        s_tvalid_i = 1'b0;
  logic        s_tready_o;
  logic        s_tlast_i = 1'b0;
  logic [31:0] xy_0_i = '0;
  logic [31:0] xy_1_i = '0;
  logic [7:0]  m_tdata_o;
  logic        m_tvalid_o;
  logic        m_tready_i = 1'b1;
  logic        m_tuser_o;
  logic        m_tlast_o;
  logic        busy_o;
  logic        err_o;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [9:0]  exp_q[$];
  bit          rand_ready = 0;
  bit          abort = 0;
  bit          prev_stall = 0;
  logic [9:0]  prev_beat = '0;
  int          beat_idx = 0;

  roi_insert_axis #(
    .WIDTH (W), .HEIGHT (H), .BIT_D (8), .BIT_C (32), .FILL (0)
  ) dut (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .s_tdata_i  (s_tdata_i),
    .s_tvalid_i (s_tvalid_i),
    .s_tready_o (s_tready_o),
    .s_tlast_i  (s_tlast_i),
    .xy_0_i     (xy_0_i),
    .xy_1_i     (xy_1_i),
    .m_tdata_o  (m_tdata_o),
    .m_tvalid_o (m_tvalid_o),
    .m_tready_i (m_tready_i),
    .m_tuser_o  (m_tuser_o),
    .m_tlast_o  (m_tlast_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] mk_xy(input int x, input int y);
    logic [31:0] v;
    v = '0;
    v[26:16] = 11'(x);
    v[9:0]   = 10'(y);
    return v;
  endfunction

  // Expected raster: the first nvalid ROI positions carry 1..nvalid, the rest 0.
  function automatic void push_frame(input int x0, input int y0, input int x1, input int y1,
                                     input int nvalid);
    int xl, xr, yt, yb, k;
    logic [7:0] d;
    xl = (x0 < x1) ? x0 : x1;
    xr = (x0 < x1) ? x1 : x0;
    yt = (y0 < y1) ? y0 : y1;
    yb = (y0 < y1) ? y1 : y0;
    k = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        d = 8'd0;
        if (c >= xl && c <= xr && r >= yt && r <= yb) begin
          k++;
          if (k <= nvalid) d = 8'(k);
        end
        exp_q.push_back({d, (r == 0 && c == 0), (c == W - 1)});
      end
    end
  endfunction

  always @(posedge clk_i) begin
    #1;
    m_tready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: a beat transfers on the next rising edge when valid && ready here.
  always @(negedge clk_i) begin
    logic [9:0] cur;
    logic [9:0] exp;
    cur = {m_tdata_o, m_tuser_o, m_tlast_o};
    if (arst_i) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(m_tvalid_o), 32'd1);
        chk("stall_beat", 32'(cur), 32'(prev_beat));
      end
      if (m_tvalid_o && m_tready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(cur), 32'h3ff);
        end else begin
          exp = exp_q.pop_front();
          chk($sformatf("beat%0d", beat_idx), 32'(cur), 32'(exp));
          beat_idx++;
        end
      end
      prev_stall = m_tvalid_o && !m_tready_i;
      prev_beat  = cur;
    end
  end

  task automatic send(input int n, input int last_idx, input bit gaps);
    int t;
    bit ok;
    for (int k = 1; k <= n && !abort; k++) begin
      s_tdata_i  = 8'(k);
      s_tlast_i  = (k == last_idx);
      s_tvalid_i = 1'b1;
      ok = 0;
      t = 0;
      while (!ok && !abort && t < 600) begin
        @(negedge clk_i);
        if (s_tready_o) ok = 1;
        t++;
      end
      if (!ok) begin
        if (!abort) begin
          n_checks++;
          n_fail++;
          $display("FAIL send_timeout: pixel %0d not accepted", k);
        end
        break;
      end
      @(posedge clk_i);
      #1;
      s_tvalid_i = 1'b0;
      s_tlast_i  = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge clk_i);
        #1;
      end
    end
    s_tvalid_i = 1'b0;
    s_tlast_i  = 1'b0;
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk_i);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_frame(input int x0, input int y0, input int x1, input int y1,
                           input int npix, input int last_idx, input int nvalid, input bit gaps);
    beat_idx = 0;
    xy_0_i = mk_xy(x0, y0);
    xy_1_i = mk_xy(x1, y1);
    push_frame(x0, y0, x1, y1, nvalid);
    fork
      send(npix, last_idx, gaps);
      wait_empty();
    join
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_reset();
    #2;
    arst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    arst_i = 1'b0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_m_tvalid", 32'(m_tvalid_o), 0);
    chk("rst_m_tdata", 32'(m_tdata_o), 0);
    chk("rst_s_tready", 32'(s_tready_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_err", 32'(err_o), 0);
    arst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    // Basic frame, then swapped corners: identical output expected.
    run_frame(2, 1, 4, 2, 6, 6, 6, 0);
    chk("basic_busy", 32'(busy_o), 0);
    chk("basic_err", 32'(err_o), 0);
    run_frame(4, 2, 2, 1, 6, 6, 6, 0);
    chk("swap_err", 32'(err_o), 0);

    // Random backpressure and input gaps.
    rand_ready = 1;
    run_frame(2, 1, 4, 2, 6, 6, 6, 1);
    rand_ready = 0;
    chk("rand_busy", 32'(busy_o), 0);
    chk("rand_err", 32'(err_o), 0);

    // Early tlast on pixel 4: remaining ROI positions become FILL.
    run_frame(2, 1, 4, 2, 4, 4, 4, 0);
    chk("early_err", 32'(err_o), 1);
    chk("early_busy", 32'(busy_o), 0);
    pulse_reset();
    chk("err_cleared", 32'(err_o), 0);

    // Missing tlast: DRAIN must swallow pixels 7 and 8.
    run_frame(2, 1, 4, 2, 8, 8, 6, 0);
    chk("drain_err", 32'(err_o), 1);
    chk("drain_busy", 32'(busy_o), 0);
    chk("drain_tready", 32'(s_tready_o), 0);
    pulse_reset();

    // Out-of-range corner: x=8 at WIDTH 8.
    xy_0_i = mk_xy(2, 1);
    xy_1_i = mk_xy(8, 1);
    s_tdata_i = 8'd1;
    s_tvalid_i = 1'b1;
    repeat (6) @(posedge clk_i);
    @(negedge clk_i);
    chk("bad_err", 32'(err_o), 1);
    chk("bad_tready", 32'(s_tready_o), 0);
    chk("bad_m_tvalid", 32'(m_tvalid_o), 0);
    chk("bad_busy", 32'(busy_o), 0);
    s_tvalid_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Reset mid-frame: outputs drop within the same cycle.
    xy_0_i = mk_xy(2, 1);
    xy_1_i = mk_xy(4, 2);
    beat_idx = 0;
    push_frame(2, 1, 4, 2, 6);
    fork
      send(6, 6, 0);
      begin
        repeat (14) @(posedge clk_i);
        #3;
        arst_i = 1'b1;
        abort = 1;
        exp_q.delete();
        #1;
        chk("mid_m_tvalid", 32'(m_tvalid_o), 0);
        chk("mid_m_tuser", 32'(m_tuser_o), 0);
        chk("mid_m_tlast", 32'(m_tlast_o), 0);
        chk("mid_m_tdata", 32'(m_tdata_o), 0);
        chk("mid_s_tready", 32'(s_tready_o), 0);
        chk("mid_busy", 32'(busy_o), 0);
        chk("mid_err", 32'(err_o), 0);
        repeat (2) @(posedge clk_i);
        #1;
        arst_i = 1'b0;
      end
    join
    abort = 0;
    @(posedge clk_i);
    #1;

    run_frame(2, 1, 4, 2, 6, 6, 6, 0);
    chk("post_rst_err", 32'(err_o), 0);
    chk("post_rst_busy", 32'(busy_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
